// File: rtl/lru_evict_ctrl.sv
// Drain controller for the LRU queue: watermark hysteresis or flush drives pops into a one-entry evict slot.
// Define LRU_EVICT_PERF_EN to build the saturating evict/stall performance counters; otherwise they read 0.
module lru_evict_ctrl #(
    parameter int DATAW   = 32,
    parameter int DEPTH   = 8,
    parameter int SIZEW   = $clog2(DEPTH + 1),
    parameter int HIGH_WM = DEPTH - 1,
    parameter int LOW_WM  = DEPTH / 2,
    parameter int CNTW    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             q_empty,
    input  logic [SIZEW-1:0] q_size,
    input  logic [DATAW-1:0] q_data,
    output logic             q_pop,
    input  logic             flush,
    output logic             flush_done,
    output logic             evict_valid,
    output logic [DATAW-1:0] evict_data,
    input  logic             evict_ready,
    output logic [CNTW-1:0]  evict_count,
    output logic [CNTW-1:0]  stall_count
);

    generate
        if (!(LOW_WM >= 0 && LOW_WM < HIGH_WM && HIGH_WM <= DEPTH)) begin : g_bad_wm
            $error("lru_evict_ctrl: need 0 <= LOW_WM < HIGH_WM <= DEPTH");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("lru_evict_ctrl: DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    localparam logic [SIZEW-1:0] HIGH_SZ = SIZEW'(HIGH_WM);
    localparam logic [SIZEW-1:0] LOW_SZ  = SIZEW'(LOW_WM);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVICT,
        ST_FLUSH
    } state_e;

    state_e           state_q, state_d;
    logic             flush_done_q, flush_done_d;
    logic             valid_q, valid_d;
    logic [DATAW-1:0] data_q, data_d;
    logic             want;
    logic             pop_c;

    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush)
                    state_d = ST_FLUSH;
                else if (q_size >= HIGH_SZ)
                    state_d = ST_EVICT;
            end
            ST_EVICT: begin
                if (flush)
                    state_d = ST_FLUSH;
                else if (q_size <= LOW_SZ)
                    state_d = ST_IDLE;
            end
            ST_FLUSH: begin
                // Flush is only complete once the slot has also been handed off.
                if (q_empty && !valid_q) begin
                    state_d      = ST_IDLE;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The low-watermark test here stops popping in the same cycle EVICT sees LOW_WM.
        want  = ((state_q == ST_EVICT) && (q_size > LOW_SZ)) || (state_q == ST_FLUSH);
        pop_c = want && !q_empty && (!valid_q || evict_ready);

        valid_d = valid_q;
        data_d  = data_q;
        if (pop_c) begin
            valid_d = 1'b1;
            data_d  = q_data;
        end else if (valid_q && evict_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            flush_done_q <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            flush_done_q <= flush_done_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
        end
    end

    assign q_pop       = pop_c;
    assign flush_done  = flush_done_q;
    assign evict_valid = valid_q;
    assign evict_data  = data_q;

`ifdef LRU_EVICT_PERF_EN
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (v == {CNTW{1'b1}}) ? v : v + CNTW'(1);
    endfunction

    logic [CNTW-1:0] evict_cnt_q, evict_cnt_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        evict_cnt_d = evict_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (valid_q && evict_ready)
            evict_cnt_d = sat_inc(evict_cnt_q);
        if (valid_q && !evict_ready)
            stall_cnt_d = sat_inc(stall_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            evict_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            evict_cnt_q <= evict_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign evict_count = evict_cnt_q;
    assign stall_count = stall_cnt_q;
`else
    assign evict_count = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_lru_evict_ctrl.sv
// Bench for lru_evict_ctrl: a small queue model feeds the DUT and a scoreboard checks the eviction order.
module tb_lru_evict_ctrl;
    localparam int DATAW   = 32;
    localparam int DEPTH   = 8;
    localparam int SIZEW   = $clog2(DEPTH + 1);
    localparam int HIGH_WM = 7;
    localparam int LOW_WM  = 4;
    localparam int CNTW    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             q_empty;
    logic [SIZEW-1:0] q_size;
    logic [DATAW-1:0] q_data;
    logic             q_pop;
    logic             flush;
    logic             flush_done;
    logic             evict_valid;
    logic [DATAW-1:0] evict_data;
    logic             evict_ready;
    logic [CNTW-1:0]  evict_count;
    logic [CNTW-1:0]  stall_count;

    lru_evict_ctrl #(
        .DATAW(DATAW), .DEPTH(DEPTH), .SIZEW(SIZEW),
        .HIGH_WM(HIGH_WM), .LOW_WM(LOW_WM), .CNTW(CNTW)
    ) dut (
        .clk(clk), .reset(reset),
        .q_empty(q_empty), .q_size(q_size), .q_data(q_data), .q_pop(q_pop),
        .flush(flush), .flush_done(flush_done),
        .evict_valid(evict_valid), .evict_data(evict_data), .evict_ready(evict_ready),
        .evict_count(evict_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Queue model: occupancy and head are registered, pops take effect at the clock edge.
    logic [DATAW-1:0] mem [0:31];
    logic [4:0]       wr_ptr = '0;
    logic [4:0]       rd_ptr = '0;
    logic             model_clr;

    assign q_size  = SIZEW'(wr_ptr - rd_ptr);
    assign q_empty = (wr_ptr == rd_ptr);
    assign q_data  = mem[rd_ptr];

    always @(posedge clk) begin
        if (model_clr)
            rd_ptr <= wr_ptr;
        else if (q_pop)
            rd_ptr <= rd_ptr + 5'd1;
    end

    int               n_checks = 0;
    int               n_errors = 0;
    int               pop_cnt  = 0;
    int               fd_cnt   = 0;
    logic [DATAW-1:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] perf(input int v);
`ifdef LRU_EVICT_PERF_EN
        return 64'(v);
`else
        return 64'(v * 0);
`endif
    endfunction

    task automatic push(input logic [DATAW-1:0] v);
        mem[wr_ptr] = v;
        wr_ptr      = wr_ptr + 5'd1;
        exp_q.push_back(v);
    endtask

    // Outputs are sampled at the falling edge; every accepted entry is scored against the queue order.
    task automatic sample();
        if (q_pop) pop_cnt++;
        if (flush_done) fd_cnt++;
        if (!reset && evict_valid && evict_ready) begin
            check_eq("sb_has_entry", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0)
                check_eq("sb_order", 64'(evict_data), 64'(exp_q.pop_front()));
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        flush       = 1'b0;
        evict_ready = 1'b1;
        model_clr   = 1'b1;
        step();
        step();
        exp_q.delete();
        model_clr = 1'b0;
        reset     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pb;
        int fb;
        int k;

        do_reset();
        reset = 1'b1;
        step();
        check_eq("rst_valid", 64'(evict_valid), 64'(0));
        check_eq("rst_data",  64'(evict_data),  64'(0));
        check_eq("rst_fd",    64'(flush_done),  64'(0));
        check_eq("rst_pop",   64'(q_pop),       64'(0));
        check_eq("rst_evcnt", 64'(evict_count), 64'(0));
        check_eq("rst_stcnt", 64'(stall_count), 64'(0));
        reset = 1'b0;

        // Watermark eviction: 7 entries drain down to LOW_WM.
        do_reset();
        pb = pop_cnt;
        for (int i = 0; i < 7; i++) push(32'(32'h10 + i));
        step();
        check_eq("t1_first_pop",  64'(q_pop), 64'(1));
        check_eq("t1_slot_empty", 64'(evict_valid), 64'(0));
        step();
        check_eq("t1_valid0", 64'(evict_valid), 64'(1));
        check_eq("t1_data0",  64'(evict_data),  64'(32'h10));
        step();
        check_eq("t1_data1",  64'(evict_data),  64'(32'h11));
        step();
        check_eq("t1_data2",  64'(evict_data),  64'(32'h12));
        check_eq("t1_stop",   64'(q_pop),       64'(0));
        repeat (4) step();
        check_eq("t1_pops",   64'(pop_cnt - pb), 64'(3));
        check_eq("t1_qsize",  64'(q_size),       64'(LOW_WM));
        check_eq("t1_idle",   64'(evict_valid),  64'(0));
        check_eq("t1_evcnt",  64'(evict_count),  perf(3));

        // Back-pressure: slot holds 0x10 while the consumer stalls.
        do_reset();
        pb = pop_cnt;
        for (int i = 0; i < 7; i++) push(32'(32'h10 + i));
        step();
        check_eq("t2_first_pop", 64'(q_pop), 64'(1));
        evict_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("t2_hold_valid", 64'(evict_valid), 64'(1));
            check_eq("t2_hold_data",  64'(evict_data),  64'(32'h10));
            check_eq("t2_no_pop",     64'(q_pop),       64'(0));
        end
        step();
        check_eq("t2_one_pop",  64'(pop_cnt - pb), 64'(1));
        check_eq("t2_stcnt",    64'(stall_count),  perf(5));
        evict_ready = 1'b1;
        repeat (6) step();
        check_eq("t2_pops",     64'(pop_cnt - pb), 64'(3));
        check_eq("t2_qsize",    64'(q_size),       64'(LOW_WM));
        check_eq("t2_evcnt",    64'(evict_count),  perf(3));

        // Flush with three queued entries.
        do_reset();
        pb = pop_cnt;
        fb = fd_cnt;
        for (int i = 0; i < 3; i++) push(32'(32'hA0 + i));
        step();
        check_eq("t3_idle_no_pop", 64'(q_pop), 64'(0));
        flush = 1'b1;
        step();
        flush = 1'b0;
        k = 0;
        while (!(q_empty && !evict_valid) && k < 20) begin
            check_eq("t3_fd_early", 64'(flush_done), 64'(0));
            step();
            k++;
        end
        check_eq("t3_drained",   64'(k < 20),    64'(1));
        check_eq("t3_fd_at_M",   64'(flush_done), 64'(0));
        step();
        check_eq("t3_fd_pulse",  64'(flush_done), 64'(1));
        step();
        check_eq("t3_fd_clear",  64'(flush_done), 64'(0));
        check_eq("t3_fd_once",   64'(fd_cnt - fb),  64'(1));
        check_eq("t3_pops",      64'(pop_cnt - pb), 64'(3));
        check_eq("t3_all_out",   64'(exp_q.size()), 64'(0));

        // Flush of an empty queue: done two cycles after the request.
        do_reset();
        pb = pop_cnt;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("t4_fd_n1",  64'(flush_done), 64'(0));
        check_eq("t4_no_pop", 64'(q_pop),      64'(0));
        step();
        check_eq("t4_fd_n2",  64'(flush_done), 64'(1));
        step();
        check_eq("t4_fd_n3",  64'(flush_done), 64'(0));
        check_eq("t4_pops",   64'(pop_cnt - pb), 64'(0));

        // Reset in the middle of a flush with the slot occupied.
        do_reset();
        for (int i = 0; i < 3; i++) push(32'(32'hB0 + i));
        evict_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("t5_pop",    64'(q_pop), 64'(1));
        step();
        step();
        check_eq("t5_valid",  64'(evict_valid), 64'(1));
        check_eq("t5_data",   64'(evict_data),  64'(32'hB0));
        check_eq("t5_stcnt",  64'(stall_count), perf(1));
        fb = fd_cnt;
        reset = 1'b1;
        step();
        check_eq("t5_rst_valid", 64'(evict_valid), 64'(0));
        check_eq("t5_rst_pop",   64'(q_pop),       64'(0));
        check_eq("t5_rst_stcnt", 64'(stall_count), 64'(0));
        check_eq("t5_rst_fd",    64'(flush_done),  64'(0));
        model_clr = 1'b1;
        exp_q.delete();
        step();
        model_clr   = 1'b0;
        reset       = 1'b0;
        evict_ready = 1'b1;
        repeat (6) step();
        check_eq("t5_no_fd",  64'(fd_cnt - fb), 64'(0));

        // 20 accepted evictions saturate a 4-bit counter.
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < ((r == 2) ? 6 : 7); i++) push(32'(32'h40 + r * 8 + i));
            step();
            flush = 1'b1;
            step();
            flush = 1'b0;
            k = 0;
            while (!flush_done && k < 40) begin
                step();
                k++;
            end
            check_eq("t6_flush_done", 64'(k < 40), 64'(1));
        end
        step();
        check_eq("t6_evcnt_sat", 64'(evict_count), perf(15));
        check_eq("t6_stcnt",     64'(stall_count), perf(0));
        check_eq("t6_all_out",   64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
